// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file operation sequencer: default widths,
// opcodes and FSM state encoding.
package regseq_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer. Carry is the ADD carry-out or the SUB
// borrow (x < y unsigned), and 0 for every other opcode.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;

  always_comb begin
    sum    = {1'b0, x} + {1'b0, y};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        result = x - y;
        carry  = (x < y);
      end
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_XOR:  result = x ^ y;
      // Shift amount is always the low three bits of Y, independent of DW.
      OP_SLL:  result = x << y[2:0];
      OP_SRL:  result = x >> y[2:0];
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Drives an external 8x8 register file as a small ALU datapath: READ, EXEC,
// WRITE per instruction. Define REGSEQ_FLAGS_EN to add the flag_z/flag_c outputs.
module regfile_op_sequencer
  import regseq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          busy,
  output logic          done
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c
`endif
);

  state_e        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rx_q;
  logic [AW-1:0] ry_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] x_q;
  logic [DW-1:0] y_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          accept;

  regseq_alu #(
    .DW (DW)
  ) u_alu (
    .op     (op_q),
    .x      (x_q),
    .y      (y_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  // Reset overrides an in-flight write so a dropped instruction never lands.
  assign WEN      = (state_q == ST_WRITE) && !Rst;
  assign done     = (state_q == ST_WRITE);
  assign RX       = rx_q;
  assign RY       = ry_q;
  assign RW       = rw_q;
  assign busW     = busw_q;

`ifdef REGSEQ_FLAGS_EN
  logic flag_z_q;
  logic flag_c_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      imm_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rw_q     <= '0;
      busw_q   <= '0;
`ifdef REGSEQ_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      // The handshake loads rs/rt straight into the read-address registers,
      // so RX/RY are valid for the whole READ cycle and hold afterwards.
      if (accept) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rx_q  <= in_rs;
        ry_q  <= in_rt;
        imm_q <= in_imm;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_READ;
        end
        ST_READ: begin
          x_q     <= busX;
          y_q     <= busY;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          // busW doubles as the result register; it holds outside WRITE.
          busw_q   <= alu_result;
          rw_q     <= rd_q;
`ifdef REGSEQ_FLAGS_EN
          flag_z_q <= (alu_result == '0);
          flag_c_q <= alu_carry;
`endif
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          state_q <= accept ? ST_READ : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
